// File: rtl/pc_seq_ctrl_pkg.sv
// Shared types and reset/trap defaults for the program-counter sequencer.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGEZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_J    = 3'd5,
        BR_JAL  = 3'd6,
        BR_JR   = 3'd7
    } br_op_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0040_0180;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch handshake plus issue/retire bundle between sequencer, instruction memory and datapath.
interface pc_seq_ctrl_if;
    import pc_ctrl_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_done;
    br_op_t      br_op;
    logic        rs_eq_rt;
    logic [31:0] rs_data;
    logic [15:0] imm16;
    logic [25:0] jidx26;

    modport master (
        output if_req, if_addr, instr, instr_valid,
        input  if_ack, if_rdata, instr_done, br_op, rs_eq_rt, rs_data, imm16, jidx26
    );

    modport slave (
        input  if_req, if_addr, instr, instr_valid,
        output if_ack, if_rdata, instr_done, br_op, rs_eq_rt, rs_data, imm16, jidx26
    );

endinterface

// File: rtl/pc_seq_ctrl_npc_calc.sv
// Combinational branch/jump resolution: taken flag, transfer target and JR alignment fault.
module npc_calc
    import pc_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  br_op_t      br_op,
    input  logic        rs_eq_rt,
    input  logic [31:0] rs_data,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx26,
    output logic        taken,
    output logic [31:0] target,
    output logic        misaligned
);

    logic        [31:0] pc4;
    logic signed [31:0] boff;
    logic        [31:0] btgt;
    logic        [31:0] jtgt;

    assign pc4  = pc + 32'd4;
    assign boff = signed'({{14{imm16[15]}}, imm16, 2'b00});
    assign btgt = pc4 + unsigned'(boff);
    assign jtgt = {pc4[31:28], jidx26, 2'b00};

    assign misaligned = (br_op == BR_JR) && (rs_data[1:0] != 2'b00);

    always_comb begin
        taken  = 1'b0;
        target = pc4;
        case (br_op)
            BR_BEQ:  begin taken = rs_eq_rt;    target = btgt;    end
            BR_BNE:  begin taken = !rs_eq_rt;   target = btgt;    end
            BR_BGEZ: begin taken = !rs_data[31]; target = btgt;   end
            BR_BLTZ: begin taken = rs_data[31]; target = btgt;    end
            BR_J,
            BR_JAL:  begin taken = 1'b1;        target = jtgt;    end
            BR_JR:   begin taken = 1'b1;        target = rs_data; end
            default: begin taken = 1'b0;        target = pc4;     end
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: fetch -> wait-for-ack -> issue-until-retire, then next-PC select.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (one architectural delay slot after taken transfers).
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    pc_seq_ctrl_if.master      bus,
    output logic [31:0]        pc,
    output logic [31:0]        link_pc,
    output logic               misalign
);

    state_t      state;
    logic        if_req_r;
    logic        valid_r;
    logic [31:0] instr_r;
    br_op_t      eff_op;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic [31:0] pc4;
    logic [31:0] npc;

    assign bus.if_req      = if_req_r;
    assign bus.if_addr     = pc;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = valid_r;
    assign pc4             = pc + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pending;
    logic [31:0] pend_tgt;

    // Transfers decoded in the delay slot are squashed to a plain sequential step.
    assign eff_op  = pending ? BR_NONE : bus.br_op;
    assign link_pc = pc + 32'd8;

    always_comb begin
        if (misaligned)    npc = TRAP_PC;
        else if (pending)  npc = pend_tgt;
        else               npc = pc4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (state == S_ISSUE && bus.instr_done) begin
            pending <= !misaligned && !pending && taken;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ISSUE && bus.instr_done && taken && !pending)
            pend_tgt <= target;
    end
`else
    assign eff_op  = bus.br_op;
    assign link_pc = pc4;

    always_comb begin
        if (misaligned)  npc = TRAP_PC;
        else if (taken)  npc = target;
        else             npc = pc4;
    end
`endif

    npc_calc u_npc_calc (
        .pc         (pc),
        .br_op      (eff_op),
        .rs_eq_rt   (bus.rs_eq_rt),
        .rs_data    (bus.rs_data),
        .imm16      (bus.imm16),
        .jidx26     (bus.jidx26),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            if_req_r <= 1'b0;
            instr_r  <= 32'd0;
            valid_r  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if_req_r <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.if_ack) begin
                        instr_r  <= bus.if_rdata;
                        if_req_r <= 1'b0;
                        valid_r  <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.instr_done) begin
                        pc      <= npc;
                        valid_r <= 1'b0;
                        state   <= S_FETCH;
                        if (misaligned)
                            misalign <= 1'b1;
                    end
                end
                default: begin
                    if_req_r <= 1'b0;
                    valid_r  <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl; delay-slot vectors are selected by BRANCH_DELAY_SLOT_EN.
module tb_pc_seq_ctrl;
    import pc_ctrl_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] TRP_PC  = 32'h0040_0180;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFF = 32'd8;
`else
    localparam logic [31:0] LINK_OFF = 32'd4;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        misalign;
    int          total;
    int          bad;

    pc_seq_ctrl_if ifb ();

    pc_seq_ctrl #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifb.master),
        .pc       (pc),
        .link_pc  (link_pc),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the sequencer in S_FETCH; one full fetch/issue/retire.
    task automatic step(input logic [31:0] addr, input br_op_t op, input logic eq,
                        input logic [31:0] rs, input logic [15:0] imm, input logic [25:0] jidx);
        int          n;
        logic [31:0] w;
        n = 0;
        w = addr ^ 32'h1234_5678;
        while (!ifb.if_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("req_lat", 32'(n), 32'd1);
        chk("if_addr", ifb.if_addr, addr);
        ifb.if_ack   = 1'b1;
        ifb.if_rdata = w;
        @(negedge clk);
        ifb.if_ack = 1'b0;
        chk("issue_vld", 32'(ifb.instr_valid), 32'd1);
        chk("instr", ifb.instr, w);
        chk("pc", pc, addr);
        chk("link_pc", link_pc, addr + LINK_OFF);
        ifb.br_op      = op;
        ifb.rs_eq_rt   = eq;
        ifb.rs_data    = rs;
        ifb.imm16      = imm;
        ifb.jidx26     = jidx;
        ifb.instr_done = 1'b1;
        @(negedge clk);
        ifb.instr_done = 1'b0;
        ifb.br_op      = BR_NONE;
        chk("vld_clr", 32'(ifb.instr_valid), 32'd0);
        chk("req_idle", 32'(ifb.if_req), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ifb.if_ack     = 1'b0;
        ifb.if_rdata   = 32'd0;
        ifb.instr_done = 1'b0;
        ifb.br_op      = BR_NONE;
        ifb.rs_eq_rt   = 1'b0;
        ifb.rs_data    = 32'd0;
        ifb.imm16      = 16'd0;
        ifb.jidx26     = 26'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", 32'(ifb.if_req), 32'd0);
        chk("rst_vld", 32'(ifb.instr_valid), 32'd0);
        chk("rst_instr", ifb.instr, 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch, 3 clocks per instruction.
        step(32'h0040_0000, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0004, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0008, BR_NONE, 0, 0, 0, 0);

`ifdef BRANCH_DELAY_SLOT_EN
        step(32'h0040_000C, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0010, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0014, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0018, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_001C, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0020, BR_BNE, 1'b0, 0, 16'h0010, 0);
        step(32'h0040_0024, BR_J, 0, 0, 0, 26'h000_0000);
        step(32'h0040_0064, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0068, BR_NONE, 0, 0, 0, 0);
`else
        step(32'h0040_000C, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0010, BR_BEQ, 1'b1, 0, 16'hFFFC, 0);
        step(32'h0040_0004, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0008, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_000C, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0010, BR_BEQ, 1'b0, 0, 16'hFFFC, 0);
        step(32'h0040_0014, BR_J, 0, 0, 0, 26'h010_0000);
        step(32'h0040_0000, BR_JAL, 0, 0, 0, 26'h010_0040);
        step(32'h0040_0100, BR_BGEZ, 0, 32'h8000_0000, 16'h0003, 0);
        step(32'h0040_0104, BR_BLTZ, 0, 32'h8000_0000, 16'h0003, 0);
        step(32'h0040_0114, BR_BNE, 1'b0, 0, 16'h0001, 0);
        step(32'h0040_011C, BR_JR, 0, 32'h0040_0200, 0, 0);
        chk("mis_ok", 32'(misalign), 32'd0);
        step(32'h0040_0200, BR_JR, 0, 32'h0040_0123, 0, 0);
        chk("mis_set", 32'(misalign), 32'd1);
        step(32'h0040_0180, BR_NONE, 0, 0, 0, 0);
        step(32'h0040_0184, BR_BGEZ, 0, 32'h0000_0001, 16'h0002, 0);
        chk("mis_hold", 32'(misalign), 32'd1);
        step(32'h0040_0190, BR_NONE, 0, 0, 0, 0);
`endif

        // Reset from S_FETCH clears the sticky flag and the PC.
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_mis", 32'(misalign), 32'd0);
        chk("rst2_pc", pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stalled memory: request and address held steady.
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(ifb.if_req), 32'd1);
            chk("stall_addr", ifb.if_addr, RST_PC);
            @(negedge clk);
        end
        ifb.if_ack   = 1'b1;
        ifb.if_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ifb.if_ack = 1'b0;
        chk("stall_vld", 32'(ifb.instr_valid), 32'd1);
        chk("stall_instr", ifb.instr, 32'hDEAD_BEEF);

        // Reset during issue drops instr_valid without waiting for a clock.
        #2 rst_n = 1'b0;
        #1;
        chk("async_vld", 32'(ifb.instr_valid), 32'd0);
        chk("async_req", 32'(ifb.if_req), 32'd0);
        chk("async_pc", pc, RST_PC);
        ifb.if_ack   = 1'b1;
        ifb.if_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ifb.if_ack = 1'b0;
        chk("stale_ack_vld", 32'(ifb.instr_valid), 32'd0);
        chk("stale_ack_req", 32'(ifb.if_req), 32'd1);
        chk("restart_addr", ifb.if_addr, RST_PC);
        ifb.if_ack   = 1'b1;
        ifb.if_rdata = 32'h0000_1111;
        @(negedge clk);
        ifb.if_ack = 1'b0;
        chk("restart_instr", ifb.instr, 32'h0000_1111);
        ifb.instr_done = 1'b1;
        @(negedge clk);
        ifb.instr_done = 1'b0;
        step(32'h0040_0004, BR_NONE, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
